// File: rtl/learn_sequencer_pkg.sv
// rtl/learn_sequencer_pkg.sv - shared sizes, neuron encodings, sequencer state encoding and sample check
package learn_sequencer_pkg;

  localparam int N_NEURONS  = 20;
  localparam int STATE_W    = 2;
  localparam int WEIGHT_W   = 10;
  localparam int LEARN_STEP = 7;
  localparam int MAX_LEARN  = 64;
  localparam int CNT_W      = $clog2(MAX_LEARN + 1);
  localparam int FILL_W     = $clog2(N_NEURONS + 1);

  localparam logic [STATE_W-1:0] NEURON_POS = 2'b01;
  localparam logic [STATE_W-1:0] NEURON_NEG = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_ACCEPT = 3'd3;
  localparam logic [2:0] S_SETUP  = 3'd4;
  localparam logic [2:0] S_PULSE  = 3'd5;
  localparam logic [2:0] S_SHIFT  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_CLEAR  = S_CLEAR,
    ST_FILL   = S_FILL,
    ST_ACCEPT = S_ACCEPT,
    ST_SETUP  = S_SETUP,
    ST_PULSE  = S_PULSE,
    ST_SHIFT  = S_SHIFT,
    ST_DONE   = S_DONE
  } seq_state_t;

  function automatic logic sample_legal(input logic [STATE_W-1:0] s);
    return (s == NEURON_POS) || (s == NEURON_NEG);
  endfunction

endpackage

// File: rtl/learn_sequencer_if.sv
// rtl/learn_sequencer_if.sv - training sample stream with valid/ready handshake
interface learn_sequencer_if;
  import learn_sequencer_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [STATE_W-1:0] s_sample;

  modport master (output s_valid, output s_sample, input s_ready);
  modport slave  (input s_valid, input s_sample, output s_ready);

endinterface

// File: rtl/learn_sequencer_neuron_history.sv
// rtl/learn_sequencer_neuron_history.sv - neuron history shift register, newest entry in the low bits
module neuron_history
  import learn_sequencer_pkg::*;
#(
  parameter int DEPTH = N_NEURONS,
  parameter int WIDTH = STATE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_shift,
  input  logic [WIDTH-1:0]       i_data,
  output logic [DEPTH*WIDTH-1:0] o_hist
);

  logic [DEPTH*WIDTH-1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
    end else if (i_shift) begin
      r_hist <= {r_hist[(DEPTH-1)*WIDTH-1:0], i_data};
    end
  end

  assign o_hist = r_hist;

endmodule

// File: rtl/learn_sequencer.sv
// rtl/learn_sequencer.sv - Hebbian learn sequencer: clear/fill/learn phases, one learn_pulse per sample
// LEARN_NO_FILL_EN: skip the fill phase and learn from the first sample on a zeroed history.
module learn_sequencer
  import learn_sequencer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  learn_sequencer_if.slave             s_bus,
  output logic [STATE_W-1:0]           xin,
  output logic [N_NEURONS*STATE_W-1:0] xalt,
  output logic                         learn_pulse,
  output logic                         weights_clr,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             learn_count,
  output logic                         err_sample
);

  seq_state_t         r_state, w_next;
  logic [STATE_W-1:0] r_xin;
  logic [CNT_W-1:0]   r_count;
  logic               r_err, r_ready, r_pulse, r_clr, r_busy, r_done;
  logic               w_hs, w_legal, w_take, w_fill_last;
  logic               w_hist_clr, w_hist_shift;
  logic [STATE_W-1:0] w_hist_data;

  assign w_hs    = s_bus.s_valid && r_ready;
  assign w_legal = sample_legal(s_bus.s_sample);
  assign w_take  = w_hs && w_legal && !stop;

`ifdef LEARN_NO_FILL_EN
  assign w_fill_last = 1'b0;
`else
  logic [FILL_W-1:0] r_fill_cnt;

  assign w_fill_last = (r_fill_cnt == FILL_W'(N_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_fill_cnt <= '0;
    end else if (r_state == ST_FILL && w_take) begin
      r_fill_cnt <= r_fill_cnt + FILL_W'(1);
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_CLEAR;
      ST_CLEAR: begin
`ifdef LEARN_NO_FILL_EN
        w_next = ST_ACCEPT;
`else
        w_next = ST_FILL;
`endif
      end
      ST_FILL:   if (w_take && w_fill_last) w_next = ST_ACCEPT;
      ST_ACCEPT: if (w_take) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_PULSE;
      ST_PULSE:  w_next = ST_SHIFT;
      ST_SHIFT:  w_next = (r_count == CNT_W'(MAX_LEARN - 1)) ? ST_DONE : ST_ACCEPT;
      ST_DONE:   if (start) w_next = ST_CLEAR;
      default:   w_next = ST_IDLE;
    endcase
    if (stop) w_next = ST_IDLE;
  end

  // Outputs decode the next state so every flag lines up with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_pulse <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_FILL) || (w_next == ST_ACCEPT);
      r_pulse <= (w_next == ST_PULSE);
      r_clr   <= (w_next == ST_CLEAR);
      r_busy  <= !((w_next == ST_IDLE) || (w_next == ST_DONE));
      r_done  <= (w_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xin   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_xin   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_ACCEPT && w_take) r_xin <= s_bus.s_sample;
      if (r_state == ST_SHIFT) r_count <= r_count + CNT_W'(1);
      if (w_hs && !w_legal) r_err <= 1'b1;
    end
  end

  assign w_hist_clr   = (r_state == ST_CLEAR);
  assign w_hist_shift = (r_state == ST_FILL && w_take) || (r_state == ST_SHIFT);
  assign w_hist_data  = (r_state == ST_SHIFT) ? r_xin : s_bus.s_sample;

  neuron_history #(
    .DEPTH (N_NEURONS),
    .WIDTH (STATE_W)
  ) u_history (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_hist_clr),
    .i_shift (w_hist_shift),
    .i_data  (w_hist_data),
    .o_hist  (xalt)
  );

  assign s_bus.s_ready = r_ready;
  assign xin           = r_xin;
  assign learn_pulse   = r_pulse;
  assign weights_clr   = r_clr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign learn_count   = r_count;
  assign err_sample    = r_err;

endmodule

// File: tb/tb_learn_sequencer.sv
// tb/tb_learn_sequencer.sv - randomized bench for learn_sequencer against a sample-level learning model
`timescale 1ns/1ps
module tb_learn_sequencer;
  import learn_sequencer_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst, start, stop;
  logic [STATE_W-1:0]           xin;
  logic [N_NEURONS*STATE_W-1:0] xalt;
  logic                         learn_pulse, weights_clr, busy, done, err_sample;
  logic [CNT_W-1:0]             learn_count;

  learn_sequencer_if bus();

  learn_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .s_bus       (bus),
    .xin         (xin),
    .xalt        (xalt),
    .learn_pulse (learn_pulse),
    .weights_clr (weights_clr),
    .busy        (busy),
    .done        (done),
    .learn_count (learn_count),
    .err_sample  (err_sample)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: history as a list of +1/-1/0, weights as plain integers.
  typedef enum {P_IDLE, P_FILL, P_ACCEPT, P_DONE} phase_t;
  phase_t m_phase;
  int     m_hist[N_NEURONS];
  int     m_w[N_NEURONS];
  int     m_xin, m_count, m_fill, m_pulses;
  bit     m_err;

  function automatic bit legal(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b11);
  endfunction

  function automatic int dec(input logic [1:0] s);
    if (s == 2'b01) return 1;
    if (s == 2'b11) return -1;
    return 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v > 0) return 2'b01;
    if (v < 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [N_NEURONS*STATE_W-1:0] pack_hist();
    logic [N_NEURONS*STATE_W-1:0] p;
    for (int j = 0; j < N_NEURONS; j++) p[2*j +: 2] = enc(m_hist[j]);
    return p;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < N_NEURONS; j++) begin
      m_hist[j] = 0;
      m_w[j]    = 0;
    end
    m_xin = 0; m_count = 0; m_fill = 0; m_err = 0;
`ifdef LEARN_NO_FILL_EN
    m_phase = P_ACCEPT;
`else
    m_phase = P_FILL;
`endif
  endtask

  task automatic model_push(input int v);
    for (int j = N_NEURONS - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = v;
  endtask

  task automatic model_accept(input logic [1:0] s);
    int v;
    v = dec(s);
    if (!legal(s)) begin
      m_err = 1;
    end else if (m_phase == P_FILL) begin
      model_push(v);
      m_fill++;
      if (m_fill == N_NEURONS) m_phase = P_ACCEPT;
    end else if (m_phase == P_ACCEPT) begin
      m_xin = v;
      for (int j = 0; j < N_NEURONS; j++) m_w[j] += LEARN_STEP * v * m_hist[j];
      model_push(v);
      m_count++;
      m_pulses++;
      if (m_count == MAX_LEARN) m_phase = P_DONE;
    end
  endtask

  // Weight block as the datapath sees it: clocked by learn_pulse, cleared by weights_clr or rst.
  int                           o_w[N_NEURONS];
  logic [N_NEURONS*STATE_W-1:0] pulse_xalt;
  logic [STATE_W-1:0]           pulse_xin;

  always @(posedge learn_pulse or posedge weights_clr or posedge rst) begin
    if (rst || weights_clr) begin
      for (int j = 0; j < N_NEURONS; j++) o_w[j] <= 0;
    end else begin
      for (int j = 0; j < N_NEURONS; j++) o_w[j] <= o_w[j] + LEARN_STEP * dec(xin) * dec(xalt[2*j +: 2]);
      pulse_xalt <= xalt;
      pulse_xin  <= xin;
    end
  end

  logic                         prev_pulse = 1'b0;
  logic [STATE_W-1:0]           prev_xin = '0;
  logic [N_NEURONS*STATE_W-1:0] prev_xalt = '0;
  int pulses = 0, clr_cycles = 0, stab_viol = 0, width_viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (learn_pulse && !prev_pulse) pulses <= pulses + 1;
      if (learn_pulse && prev_pulse) width_viol <= width_viol + 1;
      if ((learn_pulse || prev_pulse) && (xin !== prev_xin || xalt !== prev_xalt))
        stab_viol <= stab_viol + 1;
      if (weights_clr) clr_cycles <= clr_cycles + 1;
    end
    prev_pulse <= learn_pulse;
    prev_xin   <= xin;
    prev_xalt  <= xalt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, output bit ok);
    bit hs;
    int n;
    n = 0; ok = 0;
    bus.s_valid  = 1'b1;
    bus.s_sample = s;
    while (n < 50) begin
      hs = bus.s_ready;
      tick();
      n++;
      if (hs) begin
        ok = 1;
        break;
      end
    end
    bus.s_valid = 1'b0;
    check("handshake", 64'(ok), 64'd1);
  endtask

  task automatic check_weights(input string tag);
    int bad, over;
    bad = 0; over = 0;
    for (int j = 0; j < N_NEURONS; j++) begin
      if (o_w[j] != m_w[j]) bad++;
      if (o_w[j] > MAX_LEARN * LEARN_STEP || o_w[j] < -MAX_LEARN * LEARN_STEP) over++;
    end
    check(tag, 64'(bad), 64'd0);
    check({tag, "_bound"}, 64'(over), 64'd0);
  endtask

  task automatic wait_learn();
    int n;
    n = 0;
    while (!(bus.s_ready || !busy) && n < 20) begin
      tick();
      n++;
    end
    check("learn_cycles", 64'(n), 64'd3);
    check("learn_count", 64'(learn_count), 64'(m_count));
    check("xin", 64'(xin), 64'(enc(m_xin)));
    check("xalt", 64'(xalt), 64'(pack_hist()));
    check("pulse_count", 64'(pulses), 64'(m_pulses));
    check_weights("weights");
  endtask

  task automatic feed(input logic [1:0] s);
    bit     ok;
    phase_t ph;
    ph = m_phase;
    send(s, ok);
    if (ok) begin
      model_accept(s);
      if (ph == P_ACCEPT && legal(s)) wait_learn();
      else check("xalt_after_sample", 64'(xalt), 64'(pack_hist()));
    end
    check("err_flag", 64'(err_sample), 64'(m_err));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [1:0] rnd_legal();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b11;
  endfunction

  function automatic logic [1:0] rnd_illegal();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b10;
  endfunction

  logic [15:0] w_flags;
  assign w_flags = {xin, learn_pulse, weights_clr, busy, done, learn_count, err_sample, bus.s_ready, 1'b0};

  initial begin
    int bad, acc, clr_saved, iter;
    bit ok;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    bus.s_valid = 1'b0; bus.s_sample = 2'b00;
    m_pulses = 0;
    model_clear();
    m_phase = P_IDLE;
    repeat (3) tick();
    check("reset_flags", 64'(w_flags), 64'd0);
    check("reset_xalt", 64'(xalt), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 64'(bus.s_ready), 64'd0);

    // Session 1: deterministic fill of +1 with one illegal sample, then -1.
    pulse_start();
    check("clr_high", 64'(weights_clr), 64'd1);
    check("clr_busy", 64'(busy), 64'd1);
    model_clear();
    tick();
    check("clr_one_cycle", 64'(weights_clr), 64'd0);
    check("clr_cycles", 64'(clr_cycles), 64'd1);
    for (int i = 0; i < N_NEURONS; i++) begin
      if (i == 10) feed(2'b10);
      feed(2'b01);
    end
`ifndef LEARN_NO_FILL_EN
    check("fill_no_pulse", 64'(pulses), 64'd0);
    check("fill_to_accept", 64'(bus.s_ready), 64'd1);
    check("fill_xalt", 64'(xalt), 64'h55_5555_5555);
    feed(2'b11);
    check("first_pulse_xin", 64'(pulse_xin), 64'd3);
    check("first_pulse_xalt", 64'(pulse_xalt), 64'h55_5555_5555);
    check("first_count", 64'(learn_count), 64'd1);
    bad = 0;
    for (int j = 0; j < N_NEURONS; j++) if (o_w[j] != -LEARN_STEP) bad++;
    check("first_weights", 64'(bad), 64'd0);
`endif
    iter = 0;
    while (m_phase != P_DONE && iter < 300) begin
      if ($urandom_range(0, 3) == 0) feed(rnd_illegal());
      feed(rnd_legal());
      iter++;
    end
    check("done_reached", 64'(m_phase == P_DONE), 64'd1);
    check("done_flag", 64'(done), 64'd1);
    check("done_ready", 64'(bus.s_ready), 64'd0);
    check("done_count", 64'(learn_count), 64'(MAX_LEARN));
    check("done_busy", 64'(busy), 64'd0);
    acc = 0;
    bus.s_valid = 1'b1;
    bus.s_sample = 2'b01;
    for (int i = 0; i < 20; i++) begin
      if (bus.s_ready) acc++;
      tick();
    end
    bus.s_valid = 1'b0;
    check("done_no_accept", 64'(acc), 64'd0);
    check("done_hold_xalt", 64'(xalt), 64'(pack_hist()));
    check_weights("done_weights");

    // Session 2: restart from DONE, start ignored while busy, stop in SETUP.
    pulse_start();
    check("restart_clr", 64'(weights_clr), 64'd1);
    model_clear();
    tick();
    check("restart_count", 64'(learn_count), 64'd0);
    check("restart_err", 64'(err_sample), 64'd0);
    check("restart_done", 64'(done), 64'd0);
    for (int i = 0; i < N_NEURONS + 3; i++) feed(rnd_legal());
    feed(rnd_illegal());
    clr_saved = clr_cycles;
    pulse_start();
    tick();
    check("busy_start_clr", 64'(clr_cycles), 64'(clr_saved));
    check("busy_start_count", 64'(learn_count), 64'(m_count));
    check("busy_start_xalt", 64'(xalt), 64'(pack_hist()));
    check("busy_start_ready", 64'(bus.s_ready), 64'd1);
    send(rnd_legal(), ok);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_phase = P_IDLE;
    check("stop_idle", 64'(busy), 64'd0);
    check("stop_ready", 64'(bus.s_ready), 64'd0);
    check("stop_count", 64'(learn_count), 64'(m_count));
    repeat (3) tick();
    check("stop_no_pulse", 64'(pulses), 64'(m_pulses));
    check("stop_xalt", 64'(xalt), 64'(pack_hist()));
    check_weights("stop_weights");

    // Session 3: asynchronous reset while learn_pulse is high.
    pulse_start();
    model_clear();
    tick();
    for (int i = 0; i < N_NEURONS; i++) feed(rnd_legal());
    send(rnd_legal(), ok);
    iter = 0;
    while (!learn_pulse && iter < 5) begin
      tick();
      iter++;
    end
    check("pulse_seen", 64'(learn_pulse), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_drop", 64'(learn_pulse), 64'd0);
    tick();
    check("rst_flags", 64'(w_flags), 64'd0);
    check("rst_xalt", 64'(xalt), 64'd0);
    model_clear();
    m_phase = P_IDLE;
    check_weights("rst_weights");
    rst = 1'b0;
    repeat (2) tick();
    check("stability", 64'(stab_viol), 64'd0);
    check("pulse_width", 64'(width_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
